// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if: bundles the per-channel input streams, the merged output stream and arbitration controls.
// Latency: none; this is wiring only.
// Backpressure: carries in_ready and out_ready; the mux on the slave side owns in_ready and the out_* signals.
interface stream_mux_arb_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
);
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     busy;

  // Upstream sources, arbitration control and downstream sink.
  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch, busy
  );

  // The multiplexer itself.
  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch, busy
  );
endinterface

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel stream mux, fixed-select or round-robin grant, packets locked until in_last.
// Latency: 1 cycle from input handshake to registered out_valid; sustains 1 beat/cycle.
// Backpressure: 1-deep output register; in_ready is withheld while out_valid && !out_ready.
module stream_mux_arb #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_arb_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [SEL_W-1:0]  lock_ch;
  logic [SEL_W-1:0]  rr_ptr;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  out_ch_q;
  logic              busy_q;

  logic              can_accept;
  logic              g_vld;
  logic [SEL_W-1:0]  g;
  logic              g_in_vld;
  logic [DATA_W-1:0] g_data;
  logic              g_last;
  logic              xfer;

  // The output register can take a new beat when empty or being drained this cycle.
  assign can_accept = !out_valid_q || bus.out_ready;

  // Candidate grant: the locked channel, the selected channel, or the next valid channel after rr_ptr.
  always_comb begin
    g_vld = 1'b0;
    g     = '0;
    if (state == LOCKED) begin
      g_vld = 1'b1;
      g     = lock_ch;
    end else if (!bus.mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          g_vld = 1'b1;
          g     = SEL_W'(i);
        end
      end
    end else begin
      // Scan from the far end so the nearest channel after rr_ptr is the last assignment to win.
      for (int k = NUM_CH; k >= 1; k--) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (SEL_W'((int'(rr_ptr) + k) % NUM_CH) == SEL_W'(i) && bus.in_valid[i]) begin
            g_vld = 1'b1;
            g     = SEL_W'(i);
          end
        end
      end
    end
  end

  // Pick the granted channel's valid, data and last flag off the flattened input bus.
  always_comb begin
    g_in_vld = 1'b0;
    g_data   = '0;
    g_last   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g == SEL_W'(i)) begin
        g_in_vld = bus.in_valid[i];
        g_data   = bus.in_data[i*DATA_W +: DATA_W];
        g_last   = bus.in_last[i];
      end
    end
  end

  // One-hot ready towards the granted channel only; forced low while reset is held.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst_n && g_vld && can_accept && g == SEL_W'(i)) begin
        bus.in_ready[i] = 1'b1;
      end
    end
  end

  assign xfer = g_vld && g_in_vld && can_accept;

  // Output register, packet-lock FSM and round-robin pointer, all advanced by the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lock_ch     <= '0;
      rr_ptr      <= SEL_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      busy_q      <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= g_data;
      out_last_q  <= g_last;
      out_ch_q    <= g;
      if (g_last) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        rr_ptr <= g;
      end else begin
        state   <= LOCKED;
        busy_q  <= 1'b1;
        lock_ch <= g;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: scoreboard bench; the driver predicts each accepted beat, the monitor pops on output handshake.
// Latency: expects each beat one cycle after its input handshake.
// Backpressure: randomised out_ready; held beats must appear exactly once.
module tb_stream_mux_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.DATA_W(8), .NUM_CH(4)) bus4 ();
  stream_mux_arb_if #(.DATA_W(8), .NUM_CH(3)) bus3 ();

  stream_mux_arb #(.DATA_W(8), .NUM_CH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  stream_mux_arb #(.DATA_W(8), .NUM_CH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         ch;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  beat_t log_q[$];

  // Reference model state: channel holding the bus (-1 none), last channel to finish a packet, output occupancy.
  int m_lock = -1;
  int m_rr   = 3;
  bit m_ov   = 1'b0;

  // Random per-channel packet sources.
  logic [7:0] src_data[4];
  logic       src_last[4];
  int         src_left[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input bit mode, input int sel, input logic [3:0] v);
    if (m_lock >= 0) return m_lock;
    if (!mode) return (sel < 4 && v[sel]) ? sel : -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_rr + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, compare the cycle's DUT state with the model, then advance the model.
  task automatic step(input bit mode, input int sel, input logic [3:0] v, input logic [31:0] d,
                      input logic [3:0] l, input bit ordy, output int gx);
    int    g;
    bit    ca;
    int    exp_rdy;
    beat_t b;
    @(posedge clk);
    #1;
    bus4.mode      = mode;
    bus4.sel       = sel[1:0];
    bus4.in_valid  = v;
    bus4.in_data   = d;
    bus4.in_last   = l;
    bus4.out_ready = ordy;
    #1;
    check("out_valid", {31'd0, bus4.out_valid}, {31'd0, m_ov});
    check("busy", {31'd0, bus4.busy}, (m_lock >= 0) ? 32'd1 : 32'd0);
    ca      = !m_ov || ordy;
    g       = model_grant(mode, sel, v);
    exp_rdy = (g >= 0 && ca) ? (1 << g) : 0;
    check("in_ready", {28'd0, bus4.in_ready}, exp_rdy);
    gx = -1;
    if (g >= 0 && ca && v[g]) begin
      b.data = d[g*8 +: 8];
      b.last = l[g];
      b.ch   = g;
      exp_q.push_back(b);
      gx   = g;
      m_ov = 1'b1;
      if (l[g]) begin
        m_lock = -1;
        m_rr   = g;
      end else begin
        m_lock = g;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic idle_step();
    int gx;
    step(1'b0, 0, 4'h0, 32'h0, 4'h0, 1'b1, gx);
  endtask

  task automatic settle_log();
    idle_step();
    @(negedge clk);
    #1;
  endtask

  task automatic new_beat(input int c);
    if (src_left[c] == 0) src_left[c] = $urandom_range(1, 4);
    src_data[c] = 8'($urandom);
    src_last[c] = (src_left[c] == 1);
  endtask

  // Monitor: every output handshake must match the oldest predicted beat.
  initial begin
    beat_t e;
    beat_t o;
    forever begin
      @(negedge clk);
      if (rst_n && bus4.out_valid && bus4.out_ready) begin
        o.data = bus4.out_data;
        o.last = bus4.out_last;
        o.ch   = int'(bus4.out_ch);
        log_q.push_back(o);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got ch %0d data %0h, expected no beat", o.ch, o.data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, o.data}, {24'd0, e.data});
          check("out_last", {31'd0, o.last}, {31'd0, e.last});
          check("out_ch", o.ch, e.ch);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int         gx;
    logic [3:0] v;
    logic [3:0] l;
    logic [31:0] d;
    int         exp_ch2[6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] t1_dat[4]  = '{8'd10, 8'd25, 8'd100, 8'd255};

    bus4.mode = 1'b0; bus4.sel = '0; bus4.in_valid = '0; bus4.in_data = '0;
    bus4.in_last = '0; bus4.out_ready = 1'b1;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0;
    bus3.in_last = '0; bus3.out_ready = 1'b1;

    // Reset values.
    #12;
    bus4.in_valid = 4'hf;
    #1;
    check("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus4.out_data}, 32'd0);
    check("rst_out_last", {31'd0, bus4.out_last}, 32'd0);
    check("rst_out_ch", {30'd0, bus4.out_ch}, 32'd0);
    check("rst_busy", {31'd0, bus4.busy}, 32'd0);
    check("rst_in_ready", {28'd0, bus4.in_ready}, 32'd0);
    bus4.in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin straight out of reset: 0,1,2,3,0,1 back to back.
    log_q.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 0, 4'hf, 32'h44332211, 4'hf, 1'b1, gx);
    settle_log();
    check("t2_len", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) check("t2_ch_seq", log_q[i].ch, exp_ch2[i]);

    // Fixed select of each channel.
    log_q.delete();
    d = {t1_dat[3], t1_dat[2], t1_dat[1], t1_dat[0]};
    for (int s = 0; s < 4; s++) step(1'b0, s, 4'hf, d, 4'hf, 1'b1, gx);
    settle_log();
    check("t1_len", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      check("t1_data", {24'd0, log_q[i].data}, {24'd0, t1_dat[i]});
      check("t1_ch", log_q[i].ch, i);
    end

    // Packet lock: ch1 keeps the bus after sel moves to 2 until its last beat.
    log_q.delete();
    step(1'b0, 1, 4'b0110, 32'h00221100 | 32'h00001100, 4'b0100, 1'b1, gx);
    step(1'b0, 2, 4'b0110, 32'h00221200, 4'b0100, 1'b1, gx);
    check("t3_busy_mid", {31'd0, bus4.busy}, 32'd1);
    step(1'b0, 2, 4'b0110, 32'h00221300, 4'b0110, 1'b1, gx);
    check("t3_busy_mid2", {31'd0, bus4.busy}, 32'd1);
    step(1'b0, 2, 4'b0100, 32'h00220000, 4'b0100, 1'b1, gx);
    check("t3_busy_done", {31'd0, bus4.busy}, 32'd0);
    settle_log();
    check("t3_len", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t3_ch_b3", log_q[2].ch, 1);
      check("t3_data_b3", {24'd0, log_q[2].data}, 32'h13);
      check("t3_ch_next", log_q[3].ch, 2);
    end

    // Backpressure: the held beat (ch3 after the pointer settled on ch2) stays put, then drains once.
    log_q.delete();
    d = 32'h43424140;
    step(1'b1, 0, 4'hf, d, 4'hf, 1'b1, gx);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, 4'hf, d, 4'hf, 1'b0, gx);
      check("t4_hold_ch", {30'd0, bus4.out_ch}, 32'd3);
      check("t4_hold_data", {24'd0, bus4.out_data}, 32'h43);
      check("t4_hold_rdy", {28'd0, bus4.in_ready}, 32'd0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 0, 4'hf, d, 4'hf, 1'b1, gx);
    settle_log();
    check("t4_len", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t4_ch_seq", log_q[i].ch, (i + 3) % 4);

    // Reset in the middle of a locked packet.
    step(1'b1, 0, 4'b0010, 32'h0, 4'b0000, 1'b1, gx);
    step(1'b1, 0, 4'b0010, 32'h0, 4'b0000, 1'b1, gx);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", {31'd0, bus4.out_valid}, 32'd0);
    check("t5_busy", {31'd0, bus4.busy}, 32'd0);
    check("t5_in_ready", {28'd0, bus4.in_ready}, 32'd0);
    exp_q.delete();
    m_lock = -1;
    m_rr   = 3;
    m_ov   = 1'b0;
    bus4.in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    step(1'b1, 0, 4'hf, 32'h0, 4'hf, 1'b1, gx);
    check("t5_first_rdy", {28'd0, bus4.in_ready}, 32'd1);
    settle_log();
    if (log_q.size() > 0) check("t5_first_ch", log_q[0].ch, 0);
    else check("t5_first_len", log_q.size(), 1);

    // Three-channel mux with an out-of-range select never grants.
    bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.in_last = 3'b111; bus3.in_data = 24'h030201;
    for (int i = 0; i < 10; i++) begin
      idle_step();
      check("t6_in_ready", {29'd0, bus3.in_ready}, 32'd0);
      check("t6_out_valid", {31'd0, bus3.out_valid}, 32'd0);
    end
    bus3.in_valid = 3'b000;

    // Randomised traffic against the model.
    for (int c = 0; c < 4; c++) begin
      src_left[c] = 0;
      new_beat(c);
    end
    for (int n = 0; n < 3000; n++) begin
      v = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        d[c*8 +: 8] = src_data[c];
        l[c]        = src_last[c];
      end
      step(($urandom_range(0, 7) < 6) ? 1'b1 : 1'b0, $urandom_range(0, 3), v, d, l,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, gx);
      if (gx >= 0) begin
        src_left[gx]--;
        new_beat(gx);
      end
    end
    // Finish any open packets, then drain.
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < 4; c++) begin
        d[c*8 +: 8] = src_data[c];
        l[c]        = 1'b1;
      end
      step(1'b1, 0, 4'hf, d, l, 1'b1, gx);
      if (gx >= 0) begin
        src_left[gx] = 0;
        new_beat(gx);
      end
    end
    for (int n = 0; n < 3; n++) idle_step();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
